// File: rtl/hazard_pkg.sv
// Shared decode constants, FSM state type and source-usage helpers for the
// pipeline hazard controller.
package hazard_pkg;

    localparam logic [3:0] OP_LW       = 4'b1000;
    localparam logic [3:0] OP_SW       = 4'b1001;
    localparam logic [2:0] BR_PREFIX   = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        BR_WAIT  = 2'd2
    } hz_state_t;

    // The rt field takes part in the load-use compare for ALU ops, loads and
    // branches; stores get their data forwarded from MEM, so they are excluded.
    function automatic logic uses_rt(input logic [3:0] opcode);
        return ~opcode[3] | (opcode == OP_LW) | (opcode[3:1] == BR_PREFIX);
    endfunction

    function automatic logic uses_rs(input logic [3:0] opcode);
        return uses_rt(opcode) | (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_flag_tracker.sv
// Shift register following flag-setting instructions from issue until they
// update the flag register; flags are ready once nothing is in flight.
module flag_tracker #(
    parameter int FLAG_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic issue_flag,
    output logic flags_ready
);

    logic [FLAG_DEPTH-1:0] trk_reg;

    generate
        for (genvar gi = 0; gi < FLAG_DEPTH; gi++) begin : g_stage
            logic stage_in;
            if (gi == 0) begin : g_head
                assign stage_in = issue_flag;
            end else begin : g_body
                assign stage_in = trk_reg[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    trk_reg[gi] <= 1'b0;
                end else if (!hold) begin
                    trk_reg[gi] <= stage_in;
                end
            end
        end
    endgenerate

    assign flags_ready = ~|trk_reg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: load-use stalls, flag-resolution waits for conditional
// branches, taken-branch flushes and whole-pipe freeze on memory busy.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int          INST_W        = 16,
    parameter int          REG_AW        = 4,
    parameter int          LOAD_LAT      = 1,
    parameter int          FLAG_DEPTH    = 2,
    parameter logic [15:0] FLAG_SET_MASK = 16'h0077
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] if_id_inst,
    input  logic              if_id_valid,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] id_ex_rd_addr,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic              stall,
    output logic              id_bubble,
    output logic              if_flush,
    output logic              pipe_freeze,
    output logic [1:0]        hz_state
);

    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    hz_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [3:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [2:0]        cond;
    logic              is_branch;
    logic              is_uncond;
    logic              cond_br;
    logic              load_hit;
    logic              flags_ready;
    logic              issue_flag;

    assign opcode    = if_id_inst[INST_W-1 -: 4];
    assign rs        = REG_AW'(if_id_inst[7:4]);
    assign rt        = ((opcode == OP_LW) || (opcode == OP_SW)) ?
                       REG_AW'(if_id_inst[11:8]) : REG_AW'(if_id_inst[3:0]);
    assign cond      = if_id_inst[11:9];
    assign is_branch = (opcode[3:1] == BR_PREFIX);
    assign is_uncond = (cond == COND_ALWAYS);
    assign cond_br   = if_id_valid & is_branch & ~is_uncond;

    assign load_hit = if_id_valid & id_ex_memread &
                      (((id_ex_rd_addr == rs) & uses_rs(opcode)) |
                       ((id_ex_rd_addr == rt) & uses_rt(opcode)));

    // Only instructions that actually leave decode this cycle enter the tracker.
    assign issue_flag = if_id_valid & ~stall & ~if_flush & FLAG_SET_MASK[opcode];

    flag_tracker #(
        .FLAG_DEPTH (FLAG_DEPTH)
    ) u_flag_tracker (
        .clk         (clk),
        .rst         (rst),
        .hold        (mem_busy),
        .issue_flag  (issue_flag),
        .flags_ready (flags_ready)
    );

    // RUN and BR_WAIT drive identical outputs; the state only records that a
    // branch is parked waiting for flags.
    always_comb begin
        stall       = 1'b0;
        id_bubble   = 1'b0;
        if_flush    = 1'b0;
        pipe_freeze = 1'b0;
        if (rst) begin
            pipe_freeze = 1'b0;
        end else if (mem_busy) begin
            pipe_freeze = 1'b1;
        end else if (state_reg == LD_STALL) begin
            stall     = 1'b1;
            id_bubble = 1'b1;
        end else if (load_hit) begin
            stall     = 1'b1;
            id_bubble = 1'b1;
        end else if (cond_br & ~flags_ready) begin
            stall     = 1'b1;
            id_bubble = 1'b1;
        end else if (if_id_valid & is_branch & (is_uncond | br_taken)) begin
            if_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else if (!mem_busy) begin
            case (state_reg)
                LD_STALL: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    if (load_hit) begin
                        if (LOAD_LAT > 1) begin
                            state_reg <= LD_STALL;
                            cnt_reg   <= CNT_W'(LOAD_LAT - 1);
                        end else begin
                            state_reg <= RUN;
                        end
                    end else if (cond_br & ~flags_ready) begin
                        state_reg <= BR_WAIT;
                    end else begin
                        state_reg <= RUN;
                    end
                end
            endcase
        end
    end

    assign hz_state = state_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: three controllers differing only in LOAD_LAT share one
// stimulus stream; each cycle's expected outputs are queued and checked later.
module tb_hazard_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [15:0] if_id_inst;
    logic        if_id_valid;
    logic        id_ex_memread;
    logic [3:0]  id_ex_rd_addr;
    logic        br_taken;
    logic        mem_busy;

    logic [2:0]      stall_v;
    logic [2:0]      bub_v;
    logic [2:0]      flush_v;
    logic [2:0]      frz_v;
    logic [2:0][1:0] st_v;

    typedef struct {
        int         sel;
        logic [3:0] outs;   // {stall, id_bubble, if_flush, pipe_freeze}
        logic [1:0] state;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    hazard_ctrl_unit #(.LOAD_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
        .id_ex_memread(id_ex_memread), .id_ex_rd_addr(id_ex_rd_addr),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .stall(stall_v[0]), .id_bubble(bub_v[0]), .if_flush(flush_v[0]),
        .pipe_freeze(frz_v[0]), .hz_state(st_v[0])
    );

    hazard_ctrl_unit #(.LOAD_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
        .id_ex_memread(id_ex_memread), .id_ex_rd_addr(id_ex_rd_addr),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .stall(stall_v[1]), .id_bubble(bub_v[1]), .if_flush(flush_v[1]),
        .pipe_freeze(frz_v[1]), .hz_state(st_v[1])
    );

    hazard_ctrl_unit #(.LOAD_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
        .id_ex_memread(id_ex_memread), .id_ex_rd_addr(id_ex_rd_addr),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .stall(stall_v[2]), .id_bubble(bub_v[2]), .if_flush(flush_v[2]),
        .pipe_freeze(frz_v[2]), .hz_state(st_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: checks one queued expectation on every falling edge.
    initial begin
        exp_t       e;
        logic [3:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {stall_v[e.sel], bub_v[e.sel], flush_v[e.sel], frz_v[e.sel]};
                n_cmp++;
                if (got !== e.outs || st_v[e.sel] !== e.state) begin
                    n_bad++;
                    $display("FAIL %s (lat%0d): got s/b/f/z=%b st=%0d, expected s/b/f/z=%b st=%0d",
                             e.name, e.sel + 1, got, st_v[e.sel], e.outs, e.state);
                end else begin
                    $display("ok   %s (lat%0d): s/b/f/z=%b st=%0d",
                             e.name, e.sel + 1, got, st_v[e.sel]);
                end
            end
        end
    end

    task automatic cyc(input int sel, input logic s, input logic b, input logic f,
                       input logic z, input logic [1:0] st, input string nm);
        exp_t e;
        e.sel   = sel;
        e.outs  = {s, b, f, z};
        e.state = st;
        e.name  = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        if_id_inst    = 16'h0000;
        if_id_valid   = 1'b0;
        id_ex_memread = 1'b0;
        id_ex_rd_addr = 4'd0;
        br_taken      = 1'b0;
        mem_busy      = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, "reset");
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        if_id_inst = '0; if_id_valid = 0; id_ex_memread = 0;
        id_ex_rd_addr = '0; br_taken = 0; mem_busy = 0;
        @(posedge clk);
        #1;

        // Load-use, LOAD_LAT=2: ADD r1,r3,r2 behind LW r3
        do_reset();
        if_id_inst = 16'h0132; if_id_valid = 1; id_ex_memread = 1; id_ex_rd_addr = 4'd3;
        cyc(1, 1, 1, 0, 0, 0, "lu_c0");
        cyc(1, 1, 1, 0, 0, 1, "lu_c1");
        id_ex_memread = 0;
        cyc(1, 0, 0, 0, 0, 0, "lu_done");

        // Store exemption and non-comparing opcode, LOAD_LAT=1
        do_reset();
        if_id_valid = 1; id_ex_memread = 1; id_ex_rd_addr = 4'd5;
        if_id_inst = 16'h9520;
        cyc(0, 0, 0, 0, 0, 0, "sw_rt_exempt");
        if_id_inst = 16'h9550;
        cyc(0, 1, 1, 0, 0, 0, "sw_rs_hit");
        if_id_inst = 16'hA050;
        cyc(0, 0, 0, 0, 0, 0, "nocmp_opcode");
        if_id_inst = 16'h0132; id_ex_rd_addr = 4'd3; if_id_valid = 0;
        cyc(0, 0, 0, 0, 0, 0, "invalid_no_hz");
        id_ex_memread = 0;

        // Flag wait, FLAG_DEPTH=2: SUB then conditional branch
        do_reset();
        if_id_valid = 1; if_id_inst = 16'h1123;
        cyc(0, 0, 0, 0, 0, 0, "sub_issue");
        if_id_inst = 16'hC000; br_taken = 1;
        cyc(0, 1, 1, 0, 0, 0, "fw_c0");
        cyc(0, 1, 1, 0, 0, 2, "fw_c1");
        cyc(0, 0, 0, 1, 0, 2, "fw_flush");
        if_id_valid = 0; br_taken = 0;
        cyc(0, 0, 0, 0, 0, 0, "fw_after");
        if_id_valid = 1; if_id_inst = 16'hC000; br_taken = 0;
        cyc(0, 0, 0, 0, 0, 0, "br_ready_nt");
        br_taken = 1;
        cyc(0, 0, 0, 1, 0, 0, "br_ready_tk");
        if_id_valid = 0; br_taken = 0;

        // Unconditional branch ignores tracker
        do_reset();
        if_id_valid = 1; if_id_inst = 16'h1123;
        cyc(0, 0, 0, 0, 0, 0, "sub_issue2");
        if_id_inst = 16'hCE00;
        cyc(0, 0, 0, 1, 0, 0, "uncond_flush");
        if_id_valid = 0;
        cyc(0, 0, 0, 0, 0, 0, "uncond_after");

        // Freeze during LD_STALL with cnt=2, LOAD_LAT=3
        do_reset();
        if_id_inst = 16'h0132; if_id_valid = 1; id_ex_memread = 1; id_ex_rd_addr = 4'd3;
        cyc(2, 1, 1, 0, 0, 0, "fz_c0");
        mem_busy = 1;
        cyc(2, 0, 0, 0, 1, 1, "fz_hold0");
        cyc(2, 0, 0, 0, 1, 1, "fz_hold1");
        cyc(2, 0, 0, 0, 1, 1, "fz_hold2");
        mem_busy = 0;
        cyc(2, 1, 1, 0, 0, 1, "fz_c1");
        cyc(2, 1, 1, 0, 0, 1, "fz_c2");
        id_ex_memread = 0;
        cyc(2, 0, 0, 0, 0, 0, "fz_done");

        // Asynchronous reset while in BR_WAIT
        do_reset();
        if_id_valid = 1; if_id_inst = 16'h1123;
        cyc(0, 0, 0, 0, 0, 0, "sub_issue3");
        if_id_inst = 16'hC000; br_taken = 1;
        cyc(0, 1, 1, 0, 0, 0, "rb_c0");
        cyc(0, 1, 1, 0, 0, 2, "rb_c1");
        rst = 1;
        cyc(0, 0, 0, 0, 0, 0, "rst_in_brwait");
        rst = 0;
        cyc(0, 0, 0, 1, 0, 0, "post_rst_br");
        if_id_valid = 0; br_taken = 0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised, stateful hazard controller for the 16-bit pipelined core. It sits beside the IF/ID and ID/EX registers and drives PC/IF-ID hold, ID/EX bubble insertion, IF flush and a whole-pipe freeze. It tracks flag-setting instructions in flight internally instead of taking per-stage checker bits. It adds a configurable load-use penalty, a configurable flag-resolution depth and memory-busy freezing.

## Interface
- INST_W, 16, instruction width; opcode is always inst[INST_W-1 -: 4].
- REG_AW, 4, register address width.
- LOAD_LAT, 1, load-use stall cycles (≥1).
- FLAG_DEPTH, 2, stages between ID issue and flag-register update (≥1).
- FLAG_SET_MASK, 16'h0077, bit n=1 means opcode n writes flags.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- if_id_inst  in  INST_W  instruction in decode.
- if_id_valid  in  1  decode slot holds a real instruction.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rd_addr  in  REG_AW  destination of that load.
- br_taken  in  1  branch condition result for decode-stage branch; meaningful only when flags are ready.
- mem_busy  in  1  data memory not ready.
- stall  out  1  hold PC and IF/ID.
- id_bubble  out  1  zero ID/EX control this cycle.
- if_flush  out  1  squash IF/ID next edge.
- pipe_freeze  out  1  hold every pipeline register.
- hz_state  out  2  current FSM state (debug).

## Operation
- Decode fields:
  - rs = inst[7:4].
  - rt = inst[11:8] for LW (1000) and SW (1001); otherwise inst[3:0].
  - Branch = opcode[3:1]==3'b110.
  - cond = inst[11:9]; cond 3'b111 is unconditional.
- Source usage for load-use:
  - Compares are done only for opcode[3]==0, LW, SW and branch.
  - SW excludes the rt compare, because store data is MEM-forwarded.
- Load-use hit: if_id_valid & id_ex_memread & (rd==rs | (rd==rt & rt used)).
- Flag tracker:
  - trk[FLAG_DEPTH-1:0] advances each non-frozen cycle.
  - Input bit is issue_flag = if_id_valid & ~stall & ~if_flush & FLAG_SET_MASK[opcode].
  - flags_ready = ~|trk.
- FSM states: RUN(0), LD_STALL(1), BR_WAIT(2).
- RUN:
  - Load-use hit: stall=id_bubble=1. If LOAD_LAT>1, go to LD_STALL with cnt=LOAD_LAT-1.
  - Else, conditional branch with ~flags_ready: stall=id_bubble=1, go to BR_WAIT.
  - Else, unconditional branch, or conditional branch with flags_ready & br_taken: if_flush=1.
- LD_STALL:
  - stall=id_bubble=1 and cnt decrements.
  - When cnt==1, return to RUN; RUN re-evaluates the next cycle.
- BR_WAIT:
  - While ~flags_ready, stall=id_bubble=1.
  - On the first flags_ready cycle: stall=0, if_flush=br_taken, go to RUN.
- Priority: pipe_freeze > load-use > flag wait > flush.
- stall and if_flush are never both 1.
- if_id_valid=0: no hazard and no flush.
- mem_busy=1:
  - pipe_freeze=1 and stall/id_bubble/if_flush are forced 0.
  - FSM state, cnt and trk are held.
  - Evaluation resumes unchanged on the first cycle after mem_busy drops.

## Timing
- stall, id_bubble, if_flush and pipe_freeze are combinational from the current inputs and registered state.
- FSM state, cnt and trk update on the rising clk edge.
- Load-use penalty is exactly LOAD_LAT cycles, plus any freeze cycles.
- Conditional-branch wait is at most FLAG_DEPTH cycles after the last flag-setter issues.
- Flush penalty is 1 cycle.
- Reset (asynchronous, any cycle, including mid-stall): state=RUN, cnt=0, trk=0, and every output is 0 immediately.
- Outputs remain 0 until the first post-reset edge where the conditions above hold.

## Structure
- Package hazard_pkg holds:
  - opcode constants OP_LW, OP_SW and BR_PREFIX (3'b110);
  - COND_ALWAYS (3'b111);
  - the state enum (RUN/LD_STALL/BR_WAIT);
  - function uses_rt(opcode).
- Sub-module flag_tracker(FLAG_DEPTH) contains:
  - the shift register;
  - ports clk, rst, hold, issue_flag, flags_ready.
- The top level contains the decode compares, the FSM and the cnt.

## Test plan
- Load-use: LW r3 in EX (id_ex_memread=1, rd=3), decode ADD r1,r3,r2, LOAD_LAT=2 -> stall=id_bubble=1 for exactly 2 cycles, then 0. hz_state goes 0→1→0.
- Store exemption: id_ex_rd=5, decode SW with inst[11:8]=5 and rs=2 -> no stall. Same case with rs=5 -> 1-cycle stall (LOAD_LAT=1).
- Flag wait: SUB issued, next cycle conditional branch cond=000 with FLAG_DEPTH=2 -> stall for 2 cycles. Then stall=0 and, with br_taken=1, if_flush=1 for 1 cycle.
- Unconditional: decode branch cond=111 with trk nonzero -> no stall, if_flush=1 same cycle.
- Freeze: assert mem_busy for 3 cycles in the middle of an LD_STALL with cnt=2 -> pipe_freeze=1 and stall=0 during the freeze. After release the remaining stall cycles complete, with the total stall count unchanged.
- Reset: assert rst in BR_WAIT -> all outputs 0 and hz_state=0 immediately. The first post-reset conditional branch does not wait (trk=0).
